// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: queue entry layout and defaults.
package fetch_pkg;

  localparam int N              = 64;
  localparam int INSTR_W        = 32;
  localparam int DEFAULT_PC_INC = 4;

  typedef struct packed {
    logic [N-1:0]       pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-stage bundle: redirect, instruction-memory port and decode handshake.
interface fetch_queue_if #(
  parameter int N     = 64,
  parameter int DEPTH = 4
);

  logic                       PCSrc_F;
  logic [N-1:0]               PCBranch_F;
  logic [N-1:0]               imem_addr_F;
  logic [31:0]                imem_data_F;
  logic [31:0]                instr_D;
  logic [N-1:0]               pc_D;
  logic                       valid_D;
  logic                       ready_D;
  logic [$clog2(DEPTH+1)-1:0] count_F;

  modport master (
    input  PCSrc_F, PCBranch_F, imem_data_F, ready_D,
    output imem_addr_F, instr_D, pc_D, valid_D, count_F
  );

  modport slave (
    output PCSrc_F, PCBranch_F, imem_data_F, ready_D,
    input  imem_addr_F, instr_D, pc_D, valid_D, count_F
  );

endinterface

// File: rtl/fetch_fifo.sv
// Circular buffer of {pc, instr} entries with push, pop, flush, occupancy and a head read port.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int N     = 64,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH+1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [N-1:0]       wr_pc,
  input  logic [INSTR_W-1:0] wr_instr,
  output logic [N-1:0]       head_pc,
  output logic [INSTR_W-1:0] head_instr,
  output logic [CNT_W-1:0]   count
);

  logic [N-1:0]       pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PTR_W-1:0]   head_ptr;
  logic [PTR_W-1:0]   tail_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + 1'b1;
      if (pop)  head_ptr <= head_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the head is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_ptr]    <= wr_pc;
      instr_mem[tail_ptr] <= wr_instr;
    end
  end

  assign head_pc    = pc_mem[head_ptr];
  assign head_instr = instr_mem[head_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: PC register with branch redirect feeding a decoupling instruction queue.
// Optional same-cycle bypass of an empty queue when FETCH_BYPASS_EN is defined.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int           N        = 64,
  parameter int           DEPTH    = 4,
  parameter logic [N-1:0] RESET_PC = '0,
  parameter int           PC_INC   = DEFAULT_PC_INC
) (
  input  logic      clk,
  input  logic      reset,
  fetch_queue_if.master fq
);

  localparam int CNT_W = $clog2(DEPTH+1);

  logic [N-1:0]       pc_p0;
  logic [CNT_W-1:0]   count;
  logic [N-1:0]       head_pc;
  logic [INSTR_W-1:0] head_instr;
  logic               q_valid;
  logic               fifo_pop;
  logic               fifo_push;
  logic               bypass_vld;
  logic               bypass_take;
  logic               pc_adv;

  assign q_valid = (count != '0);

`ifdef FETCH_BYPASS_EN
  // Held off during reset so nothing is presented to decode before the PC is defined.
  assign bypass_vld  = ~q_valid & ~fq.PCSrc_F & ~reset;
  assign bypass_take = bypass_vld & fq.ready_D;
`else
  assign bypass_vld  = 1'b0;
  assign bypass_take = 1'b0;
`endif

  assign fifo_pop  = q_valid & fq.ready_D;
  assign fifo_push = ~fq.PCSrc_F & ((count < CNT_W'(DEPTH)) | fifo_pop) & ~bypass_take;
  assign pc_adv    = fifo_push | bypass_take;

  // PC stage: redirect wins over sequential advance; a full, stalled queue holds the PC.
  always_ff @(posedge clk) begin
    if (reset)               pc_p0 <= RESET_PC;
    else if (fq.PCSrc_F)     pc_p0 <= fq.PCBranch_F;
    else if (pc_adv)         pc_p0 <= pc_p0 + N'(PC_INC);
  end

  fetch_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (fifo_push),
    .pop        (fifo_pop),
    .flush      (fq.PCSrc_F),
    .wr_pc      (pc_p0),
    .wr_instr   (fq.imem_data_F),
    .head_pc    (head_pc),
    .head_instr (head_instr),
    .count      (count)
  );

  always_comb begin
    fq.valid_D = q_valid;
    fq.pc_D    = '0;
    fq.instr_D = '0;
    if (q_valid) begin
      fq.pc_D    = head_pc;
      fq.instr_D = head_instr;
    end else if (bypass_vld) begin
      fq.valid_D = 1'b1;
      fq.pc_D    = pc_p0;
      fq.instr_D = fq.imem_data_F;
    end
  end

  assign fq.imem_addr_F = pc_p0;
  assign fq.count_F     = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: imem returns PC[33:2]; N=64, DEPTH=4, RESET_PC=0.
module tb_fetch_queue;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  fetch_queue_if #(.N(64), .DEPTH(4)) fq ();

  fetch_queue #(
    .N        (64),
    .DEPTH    (4),
    .RESET_PC (64'h0),
    .PC_INC   (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .fq    (fq)
  );

  assign fq.imem_data_F = fq.imem_addr_F[33:2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset          = 1'b1;
    fq.ready_D     = 1'b1;
    fq.PCSrc_F     = 1'b0;
    fq.PCBranch_F  = '0;

    // Reset held for five cycles.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_addr",  fq.imem_addr_F, 64'h0);
      chk("rst_valid", fq.valid_D,     64'h0);
      chk("rst_count", fq.count_F,     64'h0);
      chk("rst_pc",    fq.pc_D,        64'h0);
      chk("rst_instr", fq.instr_D,     64'h0);
    end

    // Streaming with decode always ready.
    reset = 1'b0;
    #1;
`ifndef FETCH_BYPASS_EN
    chk("stream_empty_valid", fq.valid_D, 64'h0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("stream_pc",    fq.pc_D,        64'(4 * (i - 1)));
      chk("stream_instr", fq.instr_D,     64'(i - 1));
      chk("stream_addr",  fq.imem_addr_F, 64'(4 * i));
      chk("stream_count", fq.count_F,     64'h1);
      chk("stream_valid", fq.valid_D,     64'h1);
    end
`else
    chk("byp_valid", fq.valid_D, 64'h1);
    chk("byp_pc",    fq.pc_D,    64'h0);
    chk("byp_instr", fq.instr_D, 64'h0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("byp_count", fq.count_F,     64'h0);
      chk("byp_addr",  fq.imem_addr_F, 64'(4 * i));
      chk("byp_pc",    fq.pc_D,        64'(4 * i));
      chk("byp_instr", fq.instr_D,     64'(i));
      chk("byp_valid", fq.valid_D,     64'h1);
    end
`endif

    // Fill to full with decode stalled, then drain one per cycle.
    reset      = 1'b1;
    fq.ready_D = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("fill_count", fq.count_F,     64'(i));
      chk("fill_addr",  fq.imem_addr_F, 64'(4 * i));
      chk("fill_pc",    fq.pc_D,        64'h0);
      chk("fill_valid", fq.valid_D,     64'h1);
    end
    tick();
    chk("full_count", fq.count_F,     64'h4);
    chk("full_addr",  fq.imem_addr_F, 64'h10);
    chk("full_pc",    fq.pc_D,        64'h0);
    fq.ready_D = 1'b1;
    #1;
    chk("drain_head_pc",    fq.pc_D,    64'h0);
    chk("drain_head_instr", fq.instr_D, 64'h0);
    tick();
    chk("drain1_count", fq.count_F,     64'h4);
    chk("drain1_pc",    fq.pc_D,        64'h4);
    chk("drain1_instr", fq.instr_D,     64'h1);
    chk("drain1_addr",  fq.imem_addr_F, 64'h14);
    tick();
    chk("drain2_count", fq.count_F,     64'h4);
    chk("drain2_pc",    fq.pc_D,        64'h8);
    chk("drain2_addr",  fq.imem_addr_F, 64'h18);

    // Redirect with three queued entries and a concurrent pop.
    reset      = 1'b1;
    fq.ready_D = 1'b0;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("pre_redir_count", fq.count_F,     64'h3);
    chk("pre_redir_addr",  fq.imem_addr_F, 64'hC);
    fq.PCSrc_F    = 1'b1;
    fq.PCBranch_F = 64'h40;
    fq.ready_D    = 1'b1;
    tick();
    chk("redir_addr",  fq.imem_addr_F, 64'h40);
    chk("redir_count", fq.count_F,     64'h0);
    chk("redir_valid", fq.valid_D,     64'h0);
    fq.PCSrc_F = 1'b0;
    fq.ready_D = 1'b0;
    tick();
    chk("post_redir_pc",    fq.pc_D,        64'h40);
    chk("post_redir_instr", fq.instr_D,     64'h10);
    chk("post_redir_count", fq.count_F,     64'h1);
    chk("post_redir_addr",  fq.imem_addr_F, 64'h44);
    chk("post_redir_valid", fq.valid_D,     64'h1);

    // Reset and redirect together: reset wins.
    repeat (2) tick();
    chk("pre_prio_count", fq.count_F, 64'h3);
    reset         = 1'b1;
    fq.PCSrc_F    = 1'b1;
    fq.PCBranch_F = 64'h80;
    tick();
    chk("prio_addr",  fq.imem_addr_F, 64'h0);
    chk("prio_count", fq.count_F,     64'h0);
    chk("prio_valid", fq.valid_D,     64'h0);

    // PC wraps modulo 2^64 after a redirect to the top of the address space.
    reset         = 1'b0;
    fq.PCBranch_F = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    chk("wrap_redir_addr", fq.imem_addr_F, 64'hFFFF_FFFF_FFFF_FFFC);
    fq.PCSrc_F = 1'b0;
    tick();
    chk("wrap_addr",  fq.imem_addr_F, 64'h0);
    chk("wrap_pc",    fq.pc_D,        64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_instr", fq.instr_D,     64'hFFFF_FFFF);
    chk("wrap_count", fq.count_F,     64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
